// File: rtl/sparse_adder_rr_sched.sv
// Round-robin scheduler sharing one 16-bit sparse adder among NREQ requesters.
// Define ADD_CHAIN_EN to enable locked multi-beat carry chaining via req_last.

module sparse_adder_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  c;
  logic        cc;

  // Lookahead carries only at nibble boundaries; ripple inside each nibble
  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    gp = '1;
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 4; k++) begin
        gg[j] = g[4*j+k] | (p[4*j+k] & gg[j]);
        gp[j] = gp[j] & p[4*j+k];
      end
    end
    c[0] = cin;
    for (int j = 0; j < 4; j++)
      c[j+1] = gg[j] | (gp[j] & c[j]);
    sum = '0;
    cc  = 1'b0;
    for (int j = 0; j < 4; j++) begin
      cc = c[j];
      for (int k = 0; k < 4; k++) begin
        sum[4*j+k] = p[4*j+k] ^ cc;
        cc = g[4*j+k] | (p[4*j+k] & cc);
      end
    end
    cout = c[4];
  end

endmodule

module sparse_adder_rr_sched #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*16-1:0] req_a,
  input  logic [NREQ*16-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [15:0]       rsp_sum,
  output logic              rsp_cout,
  output logic [IDW-1:0]    rsp_id
);

  localparam logic S_EMPTY = 1'b0;
  localparam logic S_FULL  = 1'b1;

  logic            state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  win;
  logic            found;
  logic            free;
  logic            accept;
  logic [NREQ-1:0] grant;
  logic [15:0]     op_a;
  logic [15:0]     op_b;
  logic            op_cin;
  logic [15:0]     add_sum;
  logic            add_cout;

`ifdef ADD_CHAIN_EN
  logic            lock;
  logic [IDW-1:0]  lock_id;
`else
  logic            unused_last;
  assign unused_last = ^req_last;
`endif

  assign free = (state == S_EMPTY) | rsp_ready[rsp_id];

  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req_valid[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        win   = IDW'((int'(ptr) + k) % NREQ);
      end
    end
`ifdef ADD_CHAIN_EN
    if (lock) begin
      win   = lock_id;
      found = req_valid[lock_id];
    end
`endif
    grant = '0;
    if (free && found)
      grant[win] = 1'b1;
  end

  // Hold off all grants while reset is asserted
  assign req_ready = grant & {NREQ{rst_n}};
  assign accept    = |(req_valid & req_ready);

  always_comb begin
    op_a   = req_a[16*int'(win) +: 16];
    op_b   = req_b[16*int'(win) +: 16];
    op_cin = req_cin[win];
`ifdef ADD_CHAIN_EN
    if (lock)
      op_cin = rsp_cout;
`endif
  end

  sparse_adder_16 u_add (
    .a    (op_a),
    .b    (op_b),
    .cin  (op_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_EMPTY;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_id   <= '0;
      ptr      <= IDW'(NREQ - 1);
`ifdef ADD_CHAIN_EN
      lock     <= 1'b0;
      lock_id  <= '0;
`endif
    end else if (accept) begin
      state    <= S_FULL;
      rsp_sum  <= add_sum;
      rsp_cout <= add_cout;
      rsp_id   <= win;
      ptr      <= win;
`ifdef ADD_CHAIN_EN
      lock     <= ~req_last[win];
      lock_id  <= win;
`endif
    end else if (state == S_FULL && rsp_ready[rsp_id]) begin
      state <= S_EMPTY;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (state == S_FULL)
      rsp_valid[rsp_id] = 1'b1;
  end

endmodule

// File: tb/tb_sparse_adder_rr_sched.sv
// Directed bench for sparse_adder_rr_sched with a response scoreboard.
// Chain checks compile only when ADD_CHAIN_EN is defined.

module tb_sparse_adder_rr_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [3:0]  req_cin;
  logic [3:0]  req_last;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_ready;
  logic [15:0] rsp_sum;
  logic        rsp_cout;
  logic [1:0]  rsp_id;

  int tests = 0;
  int fails = 0;
  logic [18:0] sbq[$];
  logic tb_lock = 1'b0;
  logic last_cout = 1'b0;

  sparse_adder_rr_sched #(.NREQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_last  (req_last),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [15:0] a,
                        input logic [15:0] b, input logic c);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
    req_cin[i] = c;
  endtask

  task automatic sb_check();
    logic [18:0] e;
    logic [16:0] s;
    logic        ci;
    if (rst_n) begin
      if ((rsp_valid & rsp_ready) != 4'b0) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected_rsp", {28'b0, rsp_valid}, 32'b0);
        end else begin
          e = sbq.pop_front();
          chk("sb_valid", rsp_valid, 4'b1 << e[18:17]);
          chk("sb_id", rsp_id, e[18:17]);
          chk("sb_cout", rsp_cout, e[16]);
          chk("sb_sum", rsp_sum, e[15:0]);
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          ci = req_cin[i];
`ifdef ADD_CHAIN_EN
          if (tb_lock) ci = last_cout;
          tb_lock = ~req_last[i];
`endif
          s = {1'b0, req_a[16*i +: 16]} + {1'b0, req_b[16*i +: 16]} + 17'(ci);
          last_cout = s[16];
          sbq.push_back({2'(i), s});
        end
      end
    end
    chk("ready_onehot0", 32'($countones(req_ready) <= 1), 32'd1);
  endtask

  task automatic tick();
    @(negedge clk);
    sb_check();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    sbq.delete();
    tb_lock = 1'b0;
    last_cout = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 4'b1111;
    req_a = '0;
    req_b = '0;
    req_cin = '0;
    req_last = 4'b1111;
    rsp_ready = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 4'b0);
    chk("rst_req_ready", req_ready, 4'b0);
    chk("rst_sum", rsp_sum, 16'h0);
    chk("rst_cout", rsp_cout, 1'b0);
    chk("rst_id", rsp_id, 2'd0);
    rst_n = 1'b1;
    #1;
    chk("first_grant", req_ready, 4'b0001);

    req_valid = 4'b0001;
    set_op(0, 16'hFFFF, 16'h0001, 1'b0);
    tick();
    chk("single_valid", rsp_valid, 4'b0001);
    chk("single_sum", rsp_sum, 16'h0000);
    chk("single_cout", rsp_cout, 1'b1);
    chk("single_id", rsp_id, 2'd0);
    req_valid = 4'b0;
    rsp_ready = 4'b0001;
    tick();
    chk("single_drained", rsp_valid, 4'b0);

    apply_reset();
    req_valid = 4'b1111;
    rsp_ready = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 4; i++)
        set_op(i, 16'($urandom), 16'($urandom), 1'($urandom));
      #1;
      chk("fair_grant", req_ready, 4'b1 << (n % 4));
      tick();
    end
    req_valid = 4'b0;
    tick();

    req_valid = 4'b0100;
    set_op(2, 16'h1234, 16'h8765, 1'b1);
    tick();
    req_valid = 4'b1111;
    rsp_ready = 4'b1011;
    for (int n = 0; n < 3; n++) begin
      #1;
      chk("bp_ready", req_ready, 4'b0);
      chk("bp_sum", rsp_sum, 16'h999A);
      chk("bp_cout", rsp_cout, 1'b0);
      chk("bp_id", rsp_id, 2'd2);
      tick();
    end
    rsp_ready = 4'b0100;
    set_op(3, 16'h8000, 16'h8000, 1'b0);
    #1;
    chk("bp_same_cycle", req_ready, 4'b1000);
    tick();
    chk("bp_next_id", rsp_id, 2'd3);
    chk("bp_next_valid", rsp_valid, 4'b1000);
    chk("bp_next_sum", rsp_sum, 16'h0000);
    chk("bp_next_cout", rsp_cout, 1'b1);
    req_valid = 4'b0;
    rsp_ready = 4'b1111;
    tick();

`ifdef ADD_CHAIN_EN
    req_valid = 4'b0100;
    req_last = 4'b1011;
    set_op(2, 16'hFFFF, 16'h0000, 1'b1);
    set_op(1, 16'h0005, 16'h0006, 1'b0);
    #1;
    chk("chain_b1_grant", req_ready, 4'b0100);
    tick();
    chk("chain_b1_sum", rsp_sum, 16'h0000);
    chk("chain_b1_cout", rsp_cout, 1'b1);
    req_valid = 4'b0110;
    req_last = 4'b1111;
    set_op(2, 16'h0001, 16'h0002, 1'b0);
    #1;
    chk("chain_lock_grant", req_ready, 4'b0100);
    tick();
    chk("chain_b2_sum", rsp_sum, 16'h0004);
    chk("chain_b2_cout", rsp_cout, 1'b0);
    req_valid = 4'b0010;
    #1;
    chk("chain_unlock_grant", req_ready, 4'b0010);
    tick();
    req_valid = 4'b0;
    tick();
`endif

    req_valid = 4'b0100;
    req_last = 4'b1011;
    rsp_ready = 4'b0;
    set_op(2, 16'hFFFF, 16'h0000, 1'b1);
    #1;
    chk("ar_grant", req_ready, 4'b0100);
    tick();
    chk("ar_full", rsp_valid, 4'b0100);
    req_valid = 4'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_valid_drop", rsp_valid, 4'b0);
    chk("ar_sum_clear", rsp_sum, 16'h0);
    sbq.delete();
    tb_lock = 1'b0;
    last_cout = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 4'b1111;
    req_last = 4'b1111;
    for (int n = 0; n < 3; n++) begin
      #1;
      chk("ar_no_stale", rsp_valid, 4'b0);
      tick();
    end
    req_valid = 4'b0010;
    set_op(1, 16'h00F0, 16'h000F, 1'b1);
    #1;
    chk("ar_lock_clear", req_ready, 4'b0010);
    tick();
    req_valid = 4'b0;
    tick();
    chk("sb_empty", sbq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
